// File: rtl/nspi_feeder.sv
// Word feeder for a multi-lane SPI transmitter: takes one parallel word per
// valid/ready handshake, pulses start_tx, tracks the transmitter and idles after each frame.
module nspi_feeder #(
  parameter int CHANNEL_NUMBER  = 3,
  parameter int SPI_SIZE        = 8,
  parameter int WORDS_PER_FRAME = 384,
  parameter int GAP_CYCLES      = 64,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] in_data,
  output logic                               start_tx,
  input  logic                               tx_finish,
  output logic [SPI_SIZE-1:0]                data_out [CHANNEL_NUMBER-1:0],
  output logic                               frame_done,
  output logic                               busy,
  output logic                               tx_error
);

  localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int TCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(ACK_TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t         state_r;
  logic [WCW-1:0] word_cnt_r;
  logic [TCW-1:0] to_cnt_r;
  logic [GCW-1:0] gap_cnt_r;
  logic           timeout_s;
  logic           word_done_s;

  assign in_ready = (state_r == IDLE) & tx_finish;

  // Word completion: transmitter went low then high again, or it never acknowledged
  always_comb begin
    timeout_s   = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      WAIT_LOW: begin
        timeout_s   = tx_finish & (to_cnt_r == TO_LAST);
        word_done_s = tx_finish & (to_cnt_r == TO_LAST);
      end
      WAIT_HIGH: begin
        timeout_s   = 1'b0;
        word_done_s = tx_finish;
      end
      default: begin
        timeout_s   = 1'b0;
        word_done_s = 1'b0;
      end
    endcase
  end

  // Feeder state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      word_cnt_r <= {WCW{1'b0}};
      to_cnt_r   <= {TCW{1'b0}};
      gap_cnt_r  <= {GCW{1'b0}};
      start_tx   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      tx_error   <= 1'b0;
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
        data_out[i] <= {SPI_SIZE{1'b0}};
      end
    end else begin
      start_tx   <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
              data_out[i] <= in_data[i*SPI_SIZE +: SPI_SIZE];
            end
            start_tx <= 1'b1;
            busy     <= 1'b1;
            state_r  <= START;
          end
        end
        START: begin
          to_cnt_r <= {TCW{1'b0}};
          state_r  <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!tx_finish) begin
            state_r <= WAIT_HIGH;
          end else if (!timeout_s) begin
            to_cnt_r <= to_cnt_r + TCW'(1);
          end
        end
        WAIT_HIGH: begin
          to_cnt_r <= {TCW{1'b0}};
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + GCW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      if (timeout_s) begin
        tx_error <= 1'b1;
      end

      // A timed-out word is still counted so the frame keeps its length
      if (word_done_s) begin
        if (word_cnt_r == LAST_WORD) begin
          word_cnt_r <= {WCW{1'b0}};
          gap_cnt_r  <= {GCW{1'b0}};
          state_r    <= GAP;
        end else begin
          word_cnt_r <= word_cnt_r + WCW'(1);
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_nspi_feeder.sv
// Randomized bench for nspi_feeder: a behavioural transmitter plus an event-time
// reference model predicting every output cycle by cycle.
module tb_nspi_feeder;

  localparam int CH  = 3;
  localparam int SW  = 8;
  localparam int WPF = 4;
  localparam int GAP = 3;
  localparam int ACK = 8;
  localparam int DW  = CH * SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          start_tx;
  logic          tx_finish;
  logic [SW-1:0] data_out [CH-1:0];
  logic          frame_done;
  logic          busy;
  logic          tx_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transmitter model controls and state
  int tx_dly = 2, tx_len = 20, tx_post_rst = 0;
  bit tx_never = 1'b0;
  int tx_phase, tx_wait, tx_comp_cyc, tx_comp_cnt;

  // reference model state
  int            acc_cnt = 0;
  int            n_start_obs = 0;
  int            m_words, m_ret_cyc, m_fd_cyc, m_err_cyc, m_start_cyc, tx_seen;
  bit            m_busy, m_pending, m_err, m_never;
  logic [DW-1:0] m_word, m_dout;

  nspi_feeder #(
    .CHANNEL_NUMBER (CH),
    .SPI_SIZE       (SW),
    .WORDS_PER_FRAME(WPF),
    .GAP_CYCLES     (GAP),
    .ACK_TIMEOUT    (ACK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start_tx  (start_tx),
    .tx_finish (tx_finish),
    .data_out  (data_out),
    .frame_done(frame_done),
    .busy      (busy),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Schedule the outcome of one finished word: return to idle, or gap then frame_done
  task automatic complete_word(input int comp, input bit err);
    if ((m_words % WPF) == WPF - 1) begin
      m_ret_cyc = comp + GAP;
      m_fd_cyc  = comp + GAP;
    end else begin
      m_ret_cyc = comp;
    end
    m_words++;
    if (err && !m_err && m_err_cyc < 0) m_err_cyc = comp;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Transmitter: low dly clocks after start_tx, for len clocks; low after reset
  initial begin
    tx_finish = 1'b0; tx_phase = 3; tx_wait = 0; tx_comp_cnt = 0; tx_comp_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_finish = 1'b0; tx_phase = 3; tx_wait = tx_post_rst;
      end else begin
        case (tx_phase)
          0: if (start_tx && !tx_never) begin tx_wait = tx_dly; tx_phase = 1; end
          1: begin
            tx_wait--;
            if (tx_wait == 0) begin tx_finish = 1'b0; tx_wait = tx_len; tx_phase = 2; end
          end
          2: begin
            tx_wait--;
            if (tx_wait == 0) begin
              tx_finish = 1'b1; tx_comp_cyc = cyc + 1; tx_comp_cnt++; tx_phase = 0;
            end
          end
          default: begin
            if (tx_wait == 0) begin tx_finish = 1'b1; tx_phase = 0; end
            else tx_wait--;
          end
        endcase
      end
    end
  end

  // Reference model and per-cycle comparison, sampled on the falling edge
  initial begin
    logic [DW-1:0] obs_dout;
    bit exp_start, exp_fd, exp_ready;
    forever begin
      @(negedge clk);
      exp_start = 1'b0;
      exp_fd    = 1'b0;
      if (!rst_n) begin
        m_words = 0; m_busy = 1'b0; m_pending = 1'b0; m_err = 1'b0; m_never = 1'b0;
        m_ret_cyc = -1; m_fd_cyc = -1; m_err_cyc = -1; m_start_cyc = -1;
        m_dout = '0; tx_seen = tx_comp_cnt;
      end else begin
        if (tx_comp_cnt != tx_seen) begin
          tx_seen = tx_comp_cnt;
          complete_word(tx_comp_cyc, 1'b0);
        end
        if (cyc == m_ret_cyc) m_busy = 1'b0;
        if (cyc == m_err_cyc) m_err = 1'b1;
        exp_fd    = (cyc == m_fd_cyc);
        exp_start = (cyc == m_start_cyc);
        if (exp_start) begin
          m_pending = 1'b0; m_busy = 1'b1; m_dout = m_word;
          if (m_never) complete_word(cyc + 1 + ACK, 1'b1);
        end
      end
      exp_ready = !m_busy && !m_pending && tx_finish;
      for (int i = 0; i < CH; i++) obs_dout[i*SW +: SW] = data_out[i];
      if (rst_n && start_tx) n_start_obs++;
      check_value("start_tx", 32'(start_tx), 32'(exp_start));
      check_value("in_ready", 32'(in_ready), 32'(exp_ready));
      check_value("busy", 32'(busy), 32'(m_busy));
      check_value("tx_error", 32'(tx_error), 32'(m_err));
      check_value("frame_done", 32'(frame_done), 32'(exp_fd));
      check_value("data_out", 32'(obs_dout), 32'(m_dout));
      if (rst_n && in_valid && exp_ready) begin
        m_pending = 1'b1; m_start_cyc = cyc + 1; m_word = in_data; m_never = tx_never;
        acc_cnt++;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] w, input int dly, input int len,
                           input bit never, input bit keep);
    int base;
    int k;
    tx_dly = dly; tx_len = len; tx_never = never;
    in_data = w; in_valid = 1'b1;
    base = acc_cnt;
    k = 0;
    while (acc_cnt == base && k < 400) begin tick(); k++; end
    check_value("accept_wait", 32'(acc_cnt - base), 32'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_pending || m_busy || tx_phase != 0) && k < 600) begin tick(); k++; end
    check_value("idle_wait", 32'(k < 600), 32'd1);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 24'hA5_3C_0F;
    tx_post_rst = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    // first word held off by the transmitter's low status after reset
    send_word(24'hA5_3C_0F, 2, 20, 1'b0, 1'b0);
    wait_idle();

    // back-to-back words with in_valid held high
    for (int i = 0; i < 4; i++)
      send_word(rnd_word(), $urandom_range(1, 4), $urandom_range(1, 6), 1'b0, i < 3);
    wait_idle();

    // random traffic spanning two frame boundaries
    for (int i = 0; i < 9; i++) begin
      send_word(rnd_word(), $urandom_range(1, 4), $urandom_range(1, 6), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    // unresponsive transmitter, then a normal word with the error still set
    send_word(rnd_word(), 1, 1, 1'b1, 1'b0);
    wait_idle();
    send_word(rnd_word(), 2, 3, 1'b0, 1'b0);
    wait_idle();

    // clean restart, then reset while word 2 is in WAIT_HIGH
    tx_post_rst = 1;
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    send_word(rnd_word(), 2, 3, 1'b0, 1'b0);
    wait_idle();
    send_word(rnd_word(), 2, 3, 1'b0, 1'b0);
    wait_idle();
    send_word(rnd_word(), 1, 15, 1'b0, 1'b0);
    begin
      int k;
      k = 0;
      while (tx_phase != 2 && k < 50) begin tick(); k++; end
      check_value("wait_high_reach", 32'(k < 50), 32'd1);
    end
    repeat (3) tick();
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      send_word(rnd_word(), $urandom_range(1, 4), $urandom_range(1, 6), 1'b0,
                (i < 7) && ($urandom_range(0, 1) == 1));
    wait_idle();
    repeat (5) tick();

    check_value("start_count", 32'(n_start_obs), 32'(acc_cnt));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
